sevenseg_capture: RTL and testbench



---
 rtl/sevenseg_capture_pkg.sv | 16 +
 rtl/seg_pattern_decode.sv | 29 ++
 rtl/sevenseg_capture.sv | 104 ++++++++++
 tb/tb_sevenseg_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_capture_pkg.sv
// sevenseg_capture_pkg: glyph table, blank pattern and FSM states shared with the display encoder
package sevenseg_capture_pkg;

    // Active-low {g,f,e,d,c,b,a} glyphs; index is the hex nibble shown.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: 7-segment pattern to nibble and legal flag; SEGCAP_BLANK_EN adds a blank flag
module seg_pattern_decode
    import sevenseg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       legal
`ifdef SEGCAP_BLANK_EN
    ,
    output logic       blank
`endif
);

    // Table lookup against the shared glyph set; blank decodes to nibble 0.
    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        for (int k = 0; k < 16; k++)
            if (pattern == GLYPHS[k]) begin
                nibble = 4'(k);
                legal  = 1'b1;
            end
`ifdef SEGCAP_BLANK_EN
        blank = pattern == SEG_BLANK;
        legal = legal | blank;
`endif
    end

endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: recovers a multiplexed 7-segment frame into a hex word; SEGCAP_BLANK_EN accepts blank digits
module sevenseg_capture
    import sevenseg_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              hex_display,
    input  logic [NUM_DIGITS-1:0]   anode_n,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    value_valid,
    output logic [NUM_DIGITS-1:0]   err_mask
`ifdef SEGCAP_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank_mask
`endif
);

    logic [6:0]              hd_s1, hd_s2, hd_p;
    logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_p;
    logic [NUM_DIGITS-1:0]   sel, captured;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              nibble;
    logic                    legal, same, one_hot, accept, full;
    state_t                  state;
`ifdef SEGCAP_BLANK_EN
    logic                    blank;
    logic [NUM_DIGITS-1:0]   blank_sh;
`endif

    seg_pattern_decode u_dec (
        .pattern (hd_s2),
        .nibble  (nibble),
        .legal   (legal)
`ifdef SEGCAP_BLANK_EN
        ,
        .blank   (blank)
`endif
    );

    assign sel     = ~an_s2;
    assign same    = {an_s2, hd_s2} == {an_p, hd_p};
    assign one_hot = $countones(sel) == 1;
    assign accept  = state == SETTLE && same && cnt == CNT_W'(STABLE_CYCLES - 2);
    assign full    = &captured;

    // Two-flop synchronizers plus the previous-sample copy used for change detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hd_s1 <= '1;
            hd_s2 <= '1;
            hd_p  <= '1;
            an_s1 <= '1;
            an_s2 <= '1;
            an_p  <= '1;
        end else begin
            hd_s1 <= hex_display;
            hd_s2 <= hd_s1;
            hd_p  <= hd_s2;
            an_s1 <= anode_n;
            an_s2 <= an_s1;
            an_p  <= an_s2;
        end
    end

    // Stability FSM, digit capture and frame assembly; accept fires as the counter reaches STABLE_CYCLES-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            captured    <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            err_mask    <= '0;
`ifdef SEGCAP_BLANK_EN
            blank_sh    <= '0;
            blank_mask  <= '0;
`endif
        end else begin
            state       <= state == IDLE ? (one_hot ? SETTLE : IDLE) :
                           !same         ? (one_hot ? SETTLE : IDLE) :
                           accept        ? HOLD : state;
            cnt         <= (state == SETTLE && same) ? cnt + CNT_W'(1) : '0;
            value_valid <= full;
            captured    <= (full ? '0 : captured) | (accept ? sel : '0);
            err_mask    <= (clear_err ? '0 : err_mask) | (accept && !legal ? sel : '0);
            if (full) value <= shadow;
            for (int i = 0; i < NUM_DIGITS; i++)
                if (accept && legal && sel[i]) shadow[4*i +: 4] <= nibble;
`ifdef SEGCAP_BLANK_EN
            if (full) blank_mask <= blank_sh;
            for (int i = 0; i < NUM_DIGITS; i++)
                if (accept && legal && sel[i]) blank_sh[i] <= blank;
`endif
        end
    end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed checks of frame capture, glitch rejection, errors, latency and reset
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        reset_n, clear_err, value_valid;
    logic [6:0]  hex_display;
    logic [3:0]  anode_n, err_mask;
    logic [15:0] value;
`ifdef SEGCAP_BLANK_EN
    logic [3:0]  blank_mask;
`endif
    int checks = 0, errors = 0, vcount = 0, v0 = 0;

    sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hex_display (hex_display),
        .anode_n     (anode_n),
        .clear_err   (clear_err),
        .value       (value),
        .value_valid (value_valid),
        .err_mask    (err_mask)
`ifdef SEGCAP_BLANK_EN
        ,
        .blank_mask  (blank_mask)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (value_valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] pat, input int n);
        anode_n     = an;
        hex_display = pat;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        clear_err   = 1'b0;
        anode_n     = 4'b1111;
        hex_display = 7'b1111111;
        repeat (3) tick();
        check("reset_value", value, 0);
        check("reset_valid", value_valid, 0);
        check("reset_err", err_mask, 0);
        reset_n = 1'b1;

        v0 = vcount;
        hold(4'b1111, 7'b1111111, 100);
        check("idle_no_valid", vcount - v0, 0);

        v0 = vcount;
        hold(4'b1110, 7'b1111001, 20);
        hold(4'b1101, 7'b0100100, 20);
        hold(4'b1011, 7'b0110000, 20);
        hold(4'b0111, 7'b0011001, 20);
        check("basic_value", value, 16'h4321);
        check("basic_pulses", vcount - v0, 1);
        check("basic_err", err_mask, 0);

        v0 = vcount;
        hold(4'b1110, 7'b1111001, 20);
        hold(4'b1101, 7'b0100100, 20);
        hold(4'b1011, 7'b0001000, 5);
        hold(4'b1011, 7'b0000011, 20);
        hold(4'b0111, 7'b0011001, 20);
        check("glitch_value", value, 16'h4b21);
        check("glitch_pulses", vcount - v0, 1);

        v0 = vcount;
        hold(4'b1110, 7'b1111001, 20);
        hold(4'b1101, 7'b1010101, 20);
        hold(4'b1011, 7'b1111000, 20);
        hold(4'b0111, 7'b0011001, 20);
        check("illegal_err", err_mask, 4'b0010);
        check("illegal_value", value, 16'h4721);
        check("illegal_pulses", vcount - v0, 1);

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_err", err_mask, 0);

        anode_n     = 4'b1101;
        hex_display = 7'b1010101;
        repeat (9) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("set_beats_clear", err_mask, 4'b0010);
        hold(4'b1101, 7'b1010101, 10);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clear_again", err_mask, 0);

        hold(4'b1110, 7'b1111001, 20);
        hold(4'b1011, 7'b0000110, 20);
        v0 = vcount;
        anode_n     = 4'b0111;
        hex_display = 7'b0011001;
        repeat (10) tick();
        check("latency_early", value_valid, 0);
        tick();
        check("latency_hit", value_valid, 1);
        tick();
        check("latency_pulse_end", value_valid, 0);
        check("latency_value", value, 16'h4e21);
        hold(4'b0111, 7'b0011001, 8);
        check("latency_pulses", vcount - v0, 1);

        v0 = vcount;
        hold(4'b1100, 7'b1111001, 50);
        check("bad_anode_pulses", vcount - v0, 0);
        check("bad_anode_value", value, 16'h4e21);

        v0 = vcount;
        hold(4'b1110, 7'b0000000, 20);
        hold(4'b1101, 7'b0011000, 20);
        hold(4'b1011, 7'b1000110, 20);
        hold(4'b0111, 7'b0001110, 20);
        check("after_bad_value", value, 16'hfc98);
        check("after_bad_pulses", vcount - v0, 1);

        hold(4'b1110, 7'b1000000, 20);
        hold(4'b1101, 7'b0001000, 20);
        hold(4'b1011, 7'b0100001, 20);
        hold(4'b0111, 7'b1111111, 20);
`ifdef SEGCAP_BLANK_EN
        check("blank_value", value, 16'h0da0);
        check("blank_err", err_mask, 0);
        check("blank_mask", blank_mask, 4'b1000);
`else
        check("blank_value", value, 16'hfda0);
        check("blank_err", err_mask, 4'b1000);
`endif

        hold(4'b1110, 7'b1111001, 5);
        reset_n = 1'b0;
        #1;
        check("midreset_value", value, 0);
        check("midreset_valid", value_valid, 0);
        check("midreset_err", err_mask, 0);
`ifdef SEGCAP_BLANK_EN
        check("midreset_blank", blank_mask, 0);
`endif
        anode_n     = 4'b1111;
        hex_display = 7'b1111111;
        tick();
        reset_n = 1'b1;
        v0 = vcount;
        hold(4'b1111, 7'b1111111, 100);
        check("post_reset_idle", vcount - v0, 0);

        v0 = vcount;
        hold(4'b1101, 7'b0100100, 20);
        hold(4'b1011, 7'b0110000, 20);
        hold(4'b0111, 7'b0011001, 20);
        check("partial_no_valid", vcount - v0, 0);
        hold(4'b1110, 7'b1111001, 20);
        check("post_reset_pulses", vcount - v0, 1);
        check("post_reset_value", value, 16'h4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
